// File: rtl/store_buffer.sv
// store_buffer: word-granular store queue between the MEM stage and data memory, with load forwarding.
// Define STORE_BUFFER_COALESCE_EN to let a store merge into a matching tail entry instead of allocating.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             st_valid,
   input  logic [31:0]      st_addr,
   input  logic [31:0]      st_data,
   input  logic [3:0]       st_be,
   output logic             st_ready,
   input  logic             ld_valid,
   input  logic [31:0]      ld_addr,
   input  logic [3:0]       ld_be,
   output logic             ld_hit,
   output logic [31:0]      ld_data,
   output logic             ld_stall,
   input  logic             dm_ready,
   output logic             dm_we,
   output logic [31:0]      dm_addr,
   output logic [31:0]      dm_data,
   output logic [3:0]       dm_be,
   output logic [IDX_W:0]   count
);

   localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

   logic [29:0]      word_q [DEPTH];
   logic [29:0]      word_d [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [31:0]      data_d [DEPTH];
   logic [3:0]       be_q   [DEPTH];
   logic [3:0]       be_d   [DEPTH];
   logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [IDX_W:0]   count_q, count_d;

   logic [IDX_W-1:0] tail_idx;
   logic [IDX_W-1:0] slot;
   logic [IDX_W-1:0] fwd_idx;
   logic             fwd_found;
   logic             fwd_covered;
   logic [31:0]      fwd_mask;
   logic             pop;
   logic             coal_match;
   logic             accept;
   logic             alloc;
   logic             merge;
   logic             unused_addr_bits;

   assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};
   assign count = count_q;

   always_comb begin
      tail_idx    = wr_ptr_q - IDX_W'(1);
      pop         = reset && (count_q != '0) && dm_ready;
`ifdef STORE_BUFFER_COALESCE_EN
      // The tail may only absorb a store if it is not leaving the buffer this cycle.
      coal_match  = (count_q != '0) && (word_q[tail_idx] == st_addr[31:2])
                    && !(pop && (tail_idx == rd_ptr_q));
`else
      coal_match  = 1'b0;
`endif
      st_ready    = reset && ((count_q != FULL_COUNT) || coal_match);

      fwd_found   = 1'b0;
      fwd_idx     = rd_ptr_q;
      slot        = '0;
      // Walk oldest to youngest so the last match found is the youngest candidate.
      for (int i = 0; i < DEPTH; i++) begin
         slot = rd_ptr_q + IDX_W'(i);
         if (((IDX_W+1)'(i) < count_q) && (word_q[slot] == ld_addr[31:2])) begin
            fwd_found = 1'b1;
            fwd_idx   = slot;
         end
      end
      fwd_mask = '0;
      for (int b = 0; b < 4; b++) begin
         fwd_mask[8*b +: 8] = {8{be_q[fwd_idx][b]}};
      end
      fwd_covered = ((be_q[fwd_idx] & ld_be) == ld_be);

      ld_hit   = reset && ld_valid && fwd_found && fwd_covered;
      ld_stall = reset && ld_valid && fwd_found && !fwd_covered;
      ld_data  = ld_hit ? (data_q[fwd_idx] & fwd_mask) : '0;

      dm_we    = pop;
      dm_addr  = reset ? {word_q[rd_ptr_q], 2'b00} : '0;
      dm_data  = reset ? data_q[rd_ptr_q] : '0;
      dm_be    = reset ? be_q[rd_ptr_q] : '0;
   end

   always_comb begin
      word_d   = word_q;
      data_d   = data_q;
      be_d     = be_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      accept   = st_valid && st_ready;
      alloc    = accept && !coal_match;
      merge    = accept && coal_match;

      if (merge) begin
         for (int b = 0; b < 4; b++) begin
            if (st_be[b]) begin
               data_d[tail_idx][8*b +: 8] = st_data[8*b +: 8];
            end
         end
         be_d[tail_idx] = be_q[tail_idx] | st_be;
      end
      if (alloc) begin
         word_d[wr_ptr_q] = st_addr[31:2];
         data_d[wr_ptr_q] = st_data;
         be_d[wr_ptr_q]   = st_be;
         wr_ptr_d         = wr_ptr_q + IDX_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + IDX_W'(1);
      end
      if (alloc && !pop) begin
         count_d = count_q + (IDX_W+1)'(1);
      end else if (!alloc && pop) begin
         count_d = count_q - (IDX_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            word_q[i] <= '0;
            data_q[i] <= '0;
            be_q[i]   <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         word_q   <= word_d;
         data_q   <= data_d;
         be_q     <= be_d;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed vector table for the documented scenarios, then random traffic
// compared against a queue-based model of the store buffer.
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int IDX_W = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          st_valid;
   logic [31:0]   st_addr;
   logic [31:0]   st_data;
   logic [3:0]    st_be;
   logic          st_ready;
   logic          ld_valid;
   logic [31:0]   ld_addr;
   logic [3:0]    ld_be;
   logic          ld_hit;
   logic [31:0]   ld_data;
   logic          ld_stall;
   logic          dm_ready;
   logic          dm_we;
   logic [31:0]   dm_addr;
   logic [31:0]   dm_data;
   logic [3:0]    dm_be;
   logic [IDX_W:0] count;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
      .clk(clk), .reset(reset),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be), .st_ready(st_ready),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
      .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
      .dm_ready(dm_ready), .dm_we(dm_we), .dm_addr(dm_addr), .dm_data(dm_data), .dm_be(dm_be),
      .count(count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        rst_n;
      logic        st_v;
      logic [31:0] st_a;
      logic [31:0] st_d;
      logic [3:0]  st_b;
      logic        ld_v;
      logic [31:0] ld_a;
      logic [3:0]  ld_b;
      logic        dm_r;
      logic        e_ready;
      logic        e_we;
      logic [31:0] e_dm_addr;
      logic [31:0] e_dm_data;
      logic [3:0]  e_dm_be;
      logic        e_hit;
      logic        e_stall;
      logic [31:0] e_ld_data;
      int          e_count;
   } vec_t;

   typedef struct {
      logic [29:0] w;
      logic [31:0] d;
      logic [3:0]  b;
   } ent_t;

   vec_t vecs[$];
   ent_t model_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic r, input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                          input logic [3:0] sb, input logic lv, input logic [31:0] la, input logic [3:0] lb,
                          input logic dr, input logic erdy, input logic ewe, input logic [31:0] eda,
                          input logic [31:0] edd, input logic [3:0] edb, input logic ehit, input logic estall,
                          input logic [31:0] eld, input int ecnt);
      vec_t v;
      v.rst_n = r; v.st_v = sv; v.st_a = sa; v.st_d = sd; v.st_b = sb;
      v.ld_v = lv; v.ld_a = la; v.ld_b = lb; v.dm_r = dr;
      v.e_ready = erdy; v.e_we = ewe; v.e_dm_addr = eda; v.e_dm_data = edd; v.e_dm_be = edb;
      v.e_hit = ehit; v.e_stall = estall; v.e_ld_data = eld; v.e_count = ecnt;
      vecs.push_back(v);
   endtask

   task automatic apply_stimulus(input vec_t v);
      reset    = v.rst_n;
      st_valid = v.st_v;
      st_addr  = v.st_a;
      st_data  = v.st_d;
      st_be    = v.st_b;
      ld_valid = v.ld_v;
      ld_addr  = v.ld_a;
      ld_be    = v.ld_b;
      dm_ready = v.dm_r;
   endtask

   task automatic check_output(input int idx, input vec_t v);
      check($sformatf("v%0d st_ready", idx), 32'(st_ready), 32'(v.e_ready));
      check($sformatf("v%0d dm_we", idx), 32'(dm_we), 32'(v.e_we));
      check($sformatf("v%0d ld_hit", idx), 32'(ld_hit), 32'(v.e_hit));
      check($sformatf("v%0d ld_stall", idx), 32'(ld_stall), 32'(v.e_stall));
      check($sformatf("v%0d count", idx), 32'(count), 32'(v.e_count));
      if (v.e_we || !v.rst_n) begin
         check($sformatf("v%0d dm_addr", idx), dm_addr, v.e_dm_addr);
         check($sformatf("v%0d dm_data", idx), dm_data, v.e_dm_data);
         check($sformatf("v%0d dm_be", idx), 32'(dm_be), 32'(v.e_dm_be));
      end
      if (v.e_hit || !v.rst_n) begin
         check($sformatf("v%0d ld_data", idx), ld_data, v.e_ld_data);
      end
   endtask

   initial begin
      int          n;
      int          m;
      logic        pop;
      logic        coal;
      logic        e_rdy;
      logic        found;
      logic        e_hit;
      logic        e_stall;
      logic [31:0] e_ld;
      ent_t        t;

      reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
      ld_valid = 1'b0; ld_addr = '0; ld_be = '0; dm_ready = 1'b0;

      // reset, st_v, st_a, st_d, st_b, ld_v, ld_a, ld_b, dm_r | ready, we, dm_addr, dm_data, dm_be, hit, stall, ld_data, count
      add_vec(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 32'h10, 4'hF, 1,  0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0);
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 0,           1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0);
      add_vec(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 32'h10, 4'hF, 1,  1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0);
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 1, 32'h10, 4'h3, 1,          1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 0, 32'hDEADBEEF, 1);
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 0,           1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0);
      add_vec(1, 1, 32'h0, 32'hA0, 4'hF, 0, 32'h0, 4'h0, 0,          1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0);
      add_vec(1, 1, 32'h4, 32'hA1, 4'hF, 0, 32'h0, 4'h0, 0,          1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 1);
      add_vec(1, 1, 32'h8, 32'hA2, 4'hF, 0, 32'h0, 4'h0, 0,          1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 2);
      add_vec(1, 1, 32'hC, 32'hA3, 4'hF, 0, 32'h0, 4'h0, 0,          1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 3);
      add_vec(1, 1, 32'h100, 32'hFF, 4'hF, 0, 32'h0, 4'h0, 0,        0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 4);
      add_vec(1, 1, 32'h100, 32'hFF, 4'hF, 0, 32'h0, 4'h0, 1,        0, 1, 32'h0, 32'hA0, 4'hF, 0, 0, 32'h0, 4);
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1,           1, 1, 32'h4, 32'hA1, 4'hF, 0, 0, 32'h0, 3);
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1,           1, 1, 32'h8, 32'hA2, 4'hF, 0, 0, 32'h0, 2);
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1,           1, 1, 32'hC, 32'hA3, 4'hF, 0, 0, 32'h0, 1);
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1,           1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0);
      add_vec(1, 1, 32'h20, 32'h11223344, 4'hF, 0, 32'h0, 4'h0, 0,   1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0);
      add_vec(1, 1, 32'h24, 32'h99999999, 4'hF, 0, 32'h0, 4'h0, 0,   1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 1);
      add_vec(1, 1, 32'h20, 32'h55667788, 4'hF, 0, 32'h0, 4'h0, 0,   1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 2);
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 1, 32'h22, 4'hC, 0,          1, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h55667788, 3);
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 1, 32'h24, 4'h1, 0,          1, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h99999999, 3);
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 1, 32'h20, 4'hF, 1,          1, 1, 32'h20, 32'h11223344, 4'hF, 1, 0, 32'h55667788, 3);
      add_vec(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h20, 4'hF, 1,          0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 2);
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1,           1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0);
      add_vec(1, 1, 32'h30, 32'h000000AB, 4'h1, 0, 32'h0, 4'h0, 0,   1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0);
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 1, 32'h30, 4'hF, 0,          1, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h0, 1);
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 1, 32'h30, 4'h1, 0,          1, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h000000AB, 1);
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 1, 32'h30, 4'hF, 1,          1, 1, 32'h30, 32'h000000AB, 4'h1, 0, 1, 32'h0, 1);
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 1, 32'h30, 4'hF, 1,          1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0);
      add_vec(1, 1, 32'h50, 32'h12345678, 4'h6, 0, 32'h0, 4'h0, 0,   1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0);
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 1, 32'h50, 4'h2, 0,          1, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h00345600, 1);
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1,           1, 1, 32'h50, 32'h12345678, 4'h6, 0, 0, 32'h0, 1);
      add_vec(1, 1, 32'h40, 32'h000000AA, 4'h1, 0, 32'h0, 4'h0, 0,   1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0);
      add_vec(1, 1, 32'h40, 32'h0000BB00, 4'h2, 0, 32'h0, 4'h0, 0,   1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 1);
`ifdef STORE_BUFFER_COALESCE_EN
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 1, 32'h40, 4'h3, 0,          1, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0000BBAA, 1);
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1,           1, 1, 32'h40, 32'h0000BBAA, 4'h3, 0, 0, 32'h0, 1);
      add_vec(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 0,           0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0);
`else
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 1, 32'h40, 4'h3, 0,          1, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h0, 2);
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1,           1, 1, 32'h40, 32'h000000AA, 4'h1, 0, 0, 32'h0, 2);
      add_vec(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 0,           0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 1);
`endif
      add_vec(1, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1,           1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0);

      @(posedge clk);
      @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i]);
         #1;
         check_output(i, vecs[i]);
         @(posedge clk);
         #1;
      end

      // Random traffic on a small address window so matches, fills and merges are frequent.
      for (int cyc = 0; cyc < 400; cyc++) begin
         reset    = ($urandom_range(0, 39) != 0);
         st_valid = ($urandom_range(0, 9) < 6);
         st_addr  = 32'h200 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
         st_data  = $urandom;
         st_be    = 4'($urandom_range(1, 15));
         ld_valid = ($urandom_range(0, 1) == 1);
         ld_addr  = 32'h200 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
         ld_be    = 4'($urandom_range(1, 15));
         dm_ready = ($urandom_range(0, 9) < 4);
         #1;

         n    = model_q.size();
         pop  = reset && (n != 0) && dm_ready;
         coal = 1'b0;
`ifdef STORE_BUFFER_COALESCE_EN
         if (n >= 1 && model_q[n-1].w == st_addr[31:2] && !(pop && n == 1)) coal = 1'b1;
`endif
         e_rdy   = reset && ((n < DEPTH) || coal);
         found   = 1'b0;
         m       = 0;
         e_hit   = 1'b0;
         e_stall = 1'b0;
         e_ld    = '0;
         if (reset && ld_valid) begin
            for (int k = 0; k < n; k++) begin
               if (model_q[k].w == ld_addr[31:2]) begin
                  found = 1'b1;
                  m     = k;
               end
            end
            if (found) begin
               if ((model_q[m].b & ld_be) == ld_be) begin
                  e_hit = 1'b1;
                  for (int b = 0; b < 4; b++) begin
                     if (model_q[m].b[b]) e_ld[8*b +: 8] = model_q[m].d[8*b +: 8];
                  end
               end else begin
                  e_stall = 1'b1;
               end
            end
         end

         check($sformatf("r%0d st_ready", cyc), 32'(st_ready), 32'(e_rdy));
         check($sformatf("r%0d dm_we", cyc), 32'(dm_we), 32'(pop));
         check($sformatf("r%0d count", cyc), 32'(count), 32'(n));
         check($sformatf("r%0d ld_hit", cyc), 32'(ld_hit), 32'(e_hit));
         check($sformatf("r%0d ld_stall", cyc), 32'(ld_stall), 32'(e_stall));
         if (e_hit) check($sformatf("r%0d ld_data", cyc), ld_data, e_ld);
         if (pop) begin
            check($sformatf("r%0d dm_addr", cyc), dm_addr, {model_q[0].w, 2'b00});
            check($sformatf("r%0d dm_data", cyc), dm_data, model_q[0].d);
            check($sformatf("r%0d dm_be", cyc), 32'(dm_be), 32'(model_q[0].b));
         end

         if (!reset) begin
            model_q.delete();
         end else begin
            if (st_valid && e_rdy) begin
               if (coal) begin
                  t = model_q[n-1];
                  for (int b = 0; b < 4; b++) begin
                     if (st_be[b]) t.d[8*b +: 8] = st_data[8*b +: 8];
                  end
                  t.b = t.b | st_be;
                  model_q[n-1] = t;
               end else begin
                  t.w = st_addr[31:2];
                  t.d = st_data;
                  t.b = st_be;
                  model_q.push_back(t);
               end
            end
            if (pop) void'(model_q.pop_front());
         end
         @(posedge clk);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Word-granular store queue between the MEM-stage store path and the data memory.
- Accepts stores from the pipeline and retires them to memory one per cycle when memory is ready.
- Lets loads forward from pending stores, or stalls them when forwarding would be incomplete.

Parameters:
- DEPTH, 4: number of queue entries; must be a power of 2, at least 2.
- IDX_W, 2: pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- st_valid  in  1  store request from MEM stage.
- st_addr  in  32  store byte address; word index is st_addr[31:2].
- st_data  in  32  store data, already lane-aligned.
- st_be  in  4  byte enables; bit i covers data[8i+7:8i].
- st_ready  out  1  entry available; a store is accepted when st_valid && st_ready.
- ld_valid  in  1  load lookup request.
- ld_addr  in  32  load byte address.
- ld_be  in  4  bytes required by the load.
- ld_hit  out  1  load is fully satisfied by the buffer.
- ld_data  out  32  forwarded word; valid when ld_hit=1.
- ld_stall  out  1  partial overlap; the load must retry.
- dm_ready  in  1  memory can accept a write this cycle.
- dm_we  out  1  write strobe to memory.
- dm_addr  out  32  {head word index, 2'b00}.
- dm_data  out  32  head entry data.
- dm_be  out  4  head entry byte enables.
- count  out  IDX_W+1  occupied entries.

Behaviour:
- Storage: circular array of DEPTH entries {word index[29:0], data[31:0], be[3:0]}.
  - Pointers wr_ptr and rd_ptr wrap modulo DEPTH; count runs 0..DEPTH.
- Reset (reset=0 at an edge): wr_ptr=0, rd_ptr=0, count=0, all entries discarded.
  - While reset=0, outputs are forced combinationally: st_ready=0, dm_we=0, ld_hit=0, ld_stall=0.
  - ld_data, dm_addr, dm_data and dm_be read as 0.
  - A reset mid-drain drops every pending store; no further dm_we pulse occurs for them.
- st_ready = (count != DEPTH). A full buffer never accepts a store, even if it is popping the same cycle.
- Push: a store is written at wr_ptr; wr_ptr advances; the entry becomes visible next cycle.
  - A store accepted into an empty buffer reaches memory no earlier than the following cycle (minimum latency 1).
- Drain: dm_we = (count != 0) && dm_ready, combinational.
  - dm_addr, dm_data and dm_be always present the head entry.
  - When dm_we=1, the head is popped at the edge and rd_ptr advances.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Forwarding lookup is combinational and applies only when ld_valid=1; otherwise ld_hit=0 and ld_stall=0.
  - Candidates: valid entries whose word index equals ld_addr[31:2], including the head being popped this cycle.
  - Youngest candidate M is the one nearest wr_ptr - 1.
  - If M exists and (M.be & ld_be) == ld_be: ld_hit=1, ld_data=M.data with bytes outside M.be forced to 0.
  - If any candidate exists but M does not cover ld_be: ld_stall=1, ld_hit=0.
  - No candidate: ld_hit=0, ld_stall=0; the load reads memory directly.
- The store being pushed in the same cycle is not visible to a load in that cycle.

Optional Feature:
- Macro: STORE_BUFFER_COALESCE_EN.
- Defined: a store whose word index matches the tail entry (wr_ptr-1) merges into it instead of allocating, subject to two conditions:
  - count >= 1, and that tail entry is not the head being popped this cycle.
  - Merge rule: bytes set in st_be overwrite the tail entry's data, and tail be |= st_be.
  - st_ready for a coalescing store is 1 even when the buffer is full.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then 1 -> count=0, st_ready=1, dm_we=0.
- Single store with dm_ready=1: st_addr=0x10, st_data=0xDEADBEEF, st_be=4'hF -> next cycle dm_we=1, dm_addr=0x10, dm_data=0xDEADBEEF; count back to 0 after that edge.
- Fill with dm_ready=0: 4 stores to 0x0, 0x4, 0x8, 0xC -> count=4, st_ready=0; then dm_ready=1 -> dm_we on 4 consecutive cycles in FIFO order.
- Forward hit: buffer holds 0x20/0x11223344/4'hF and 0x20/0x55667788/4'hF, dm_ready=0; load ld_addr=0x22, ld_be=4'hC -> ld_hit=1, ld_data=0x55667788.
- Partial stall: buffer holds 0x30/0x000000AB/4'h1; load ld_addr=0x30, ld_be=4'hF -> ld_stall=1; after the drain, ld_stall=0 and ld_hit=0.
- Coalesce (macro defined): stores 0x40/0x000000AA/4'h1 then 0x40/0x0000BB00/4'h2 with dm_ready=0 -> count=1, head data=0x0000BBAA, be=4'h3; macro undefined -> count=2.
